// File: rtl/sprite_pkg.sv
// +-------------------------------------------------------------------------+
// | sprite_pkg : shared sprite geometry, draw command and drawer FSM states |
// | Revision   : 1.0                                                        |
// +-------------------------------------------------------------------------+
`default_nettype none

package sprite_pkg;

    localparam int SPR_SIZE = 16;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int PIX_W    = 4;

    typedef struct packed {
        logic [9:0] col;
        logic       flip;
        logic [7:0] frame;
        logic [3:0] rowoff;
    } draw_cmd_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DRAW = 2'd2
    } drw_state_t;

endpackage

`default_nettype wire

// File: rtl/sprite_drawer.sv
// +-------------------------------------------------------------------------+
// | sprite_drawer : fetches one 16-pixel sprite row and writes it, clipped, |
// |                 into the next-scanline line buffer.  Revision: 1.0      |
// +-------------------------------------------------------------------------+
`default_nettype none

module sprite_drawer #(
    parameter int SCREEN_W = 640,
    parameter int PIX_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_row,
    input  logic                draw_req,
    input  logic [9:0]          col_base,
    input  logic                flip,
    input  logic [7:0]          frame_id,
    input  logic [3:0]          row_off,
    output logic                draw_done,
    output logic                rom_en,
    output logic [11:0]         rom_addr,
    input  logic [16*PIX_W-1:0] rom_data,
    output logic                lb_we,
    output logic [9:0]          lb_addr,
    output logic [PIX_W-1:0]    lb_data
);
    import sprite_pkg::*;

    localparam logic [10:0] COL_LIMIT = 11'(SCREEN_W);
    localparam logic [3:0]  PX_LAST   = 4'(SPR_SIZE - 1);

    drw_state_t          state, state_nxt;
    draw_cmd_t           cmd;
    logic [9:0]          col_r;
    logic                flip_r;
    logic [16*PIX_W-1:0] row_r;
    logic [3:0]          px;
    logic [3:0]          sel;
    logic [PIX_W-1:0]    pix;
    logic [10:0]         col;
    logic                wr;

    assign cmd       = '{col: col_base, flip: flip, frame: frame_id, rowoff: row_off};
    assign rom_addr  = {cmd.frame, cmd.rowoff};
    assign draw_done = (state == S_IDLE) && !draw_req;

    assign sel = flip_r ? (PX_LAST - px) : px;
    assign pix = row_r[PIX_W*sel +: PIX_W];
    // 11-bit sum so columns past 1023 cannot wrap back into the visible range
    assign col = {1'b0, col_r} + {7'b0, px};
    assign wr  = (state == S_DRAW) && !start_row && (pix != '0) && (col < COL_LIMIT);

    always_comb begin
        state_nxt = state;
        rom_en    = 1'b0;
        case (state)
            S_IDLE: begin
                if (draw_req) begin
                    rom_en    = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD:  state_nxt = S_DRAW;
            S_DRAW:  if (px == PX_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (start_row) begin
            state_nxt = S_IDLE;
            rom_en    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            px      <= '0;
            row_r   <= '0;
            col_r   <= '0;
            flip_r  <= 1'b0;
            lb_we   <= 1'b0;
            lb_addr <= '0;
            lb_data <= '0;
        end else begin
            lb_we   <= wr;
            lb_addr <= col[9:0];
            lb_data <= pix;
            if (rom_en) begin
                col_r  <= cmd.col;
                flip_r <= cmd.flip;
            end
            if (start_row) begin
                px <= '0;
            end else if (state == S_LOAD) begin
                row_r <= rom_data;
                px    <= '0;
            end else if (state == S_DRAW) begin
                px <= px + 4'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sprite_drawer.sv
// +-------------------------------------------------------------------------+
// | tb_sprite_drawer : directed self-checking bench for sprite_drawer       |
// | Revision         : 1.0                                                  |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_sprite_drawer;

    localparam logic [63:0] P_SEQ  = 64'h1FEDCBA987654321;
    localparam logic [63:0] P_ODD  = 64'h10E0C0A080604020;

    logic        clk = 1'b0;
    logic        reset, start_row, draw_req, flip, draw_done, rom_en, lb_we;
    logic [9:0]  col_base, lb_addr;
    logic [7:0]  frame_id;
    logic [3:0]  row_off, lb_data;
    logic [11:0] rom_addr;
    logic [63:0] pat   = '0;
    logic [63:0] rom_q = '0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int nwr    = 0;
    int t0;
    bit got_first;
    logic [9:0] first_addr;
    logic [3:0] first_data;

    bit         exp_we   [0:1023];
    logic [9:0] exp_addr [0:1023];
    logic [3:0] exp_data [0:1023];

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_en) rom_q <= pat;

    sprite_drawer #(.SCREEN_W(640), .PIX_W(4)) dut (
        .clk(clk), .reset(reset), .start_row(start_row), .draw_req(draw_req),
        .col_base(col_base), .flip(flip), .frame_id(frame_id), .row_off(row_off),
        .draw_done(draw_done), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_q),
        .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (lb_we === 1'b1) begin
            nwr++;
            if (!got_first) begin
                got_first  = 1'b1;
                first_addr = lb_addr;
                first_data = lb_data;
            end
        end
        chk("lb_we", {63'b0, lb_we}, {63'b0, exp_we[cyc]});
        if (exp_we[cyc]) begin
            chk("lb_addr", {54'b0, lb_addr}, {54'b0, exp_addr[cyc]});
            chk("lb_data", {60'b0, lb_data}, {60'b0, exp_data[cyc]});
        end
    endtask

    task automatic clear_exp(input int from);
        for (int i = from; i < 1024; i++) exp_we[i] = 1'b0;
    endtask

    task automatic model(input int t, input logic [9:0] c, input logic f, input logic [63:0] p);
        for (int k = 0; k < 16; k++) begin
            int s;
            int cc;
            logic [3:0] v;
            s  = f ? 15 - k : k;
            v  = p[s*4 +: 4];
            cc = int'(c) + k;
            if (v != 4'd0 && cc < 640) begin
                exp_we[t+3+k]   = 1'b1;
                exp_addr[t+3+k] = cc[9:0];
                exp_data[t+3+k] = v;
            end
        end
    endtask

    task automatic issue(input logic [9:0] c, input logic f, input logic [7:0] fr,
                         input logic [3:0] ro, input logic [63:0] p);
        pat = p; col_base = c; flip = f; frame_id = fr; row_off = ro; draw_req = 1'b1;
        #1;
        chk("rom_en", {63'b0, rom_en}, 64'd1);
        chk("rom_addr", {52'b0, rom_addr}, {52'b0, fr, ro});
        chk("done_at_req", {63'b0, draw_done}, 64'd0);
        model(cyc, c, f, p);
    endtask

    task automatic run_cmd(input logic [9:0] c, input logic f, input logic [7:0] fr,
                           input logic [3:0] ro, input logic [63:0] p);
        nwr = 0;
        got_first = 1'b0;
        issue(c, f, fr, ro, p);
        for (int k = 1; k <= 18; k++) begin
            step();
            draw_req = 1'b0;
            #1;
            chk("draw_done_seq", {63'b0, draw_done}, (k == 18) ? 64'd1 : 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int qi, nrom;
        int acc [4];
        logic [9:0] qcol [4];
        qcol[0] = 10'd10; qcol[1] = 10'd40; qcol[2] = 10'd200; qcol[3] = 10'd300;

        reset = 1'b0; start_row = 1'b0; draw_req = 1'b0; flip = 1'b0;
        col_base = '0; frame_id = '0; row_off = '0;
        #3;
        chk("rst_done", {63'b0, draw_done}, 64'd1);
        chk("rst_we", {63'b0, lb_we}, 64'd0);
        chk("rst_rom_en", {63'b0, rom_en}, 64'd0);
        chk("rst_addr", {54'b0, lb_addr}, 64'd0);
        chk("rst_data", {60'b0, lb_data}, 64'd0);
        step(); step();
        #2 reset = 1'b1;
        repeat (3) step();
        chk("rst_nowrites", nwr, 0);

        // plain row at column 100
        run_cmd(10'd100, 1'b0, 8'h03, 4'h5, P_SEQ);
        chk("plain_count", nwr, 16);
        chk("plain_first_addr", {54'b0, first_addr}, 64'd100);
        chk("plain_first_data", {60'b0, first_data}, 64'd1);

        // mirrored, even pixels transparent
        run_cmd(10'd100, 1'b1, 8'h03, 4'h5, P_ODD);
        chk("flip_count", nwr, 8);
        chk("flip_first_addr", {54'b0, first_addr}, 64'd100);
        chk("flip_first_data", {60'b0, first_data}, 64'd1);

        run_cmd(10'd632, 1'b0, 8'h7F, 4'hF, P_SEQ);
        chk("clip632_count", nwr, 8);
        chk("clip632_first", {54'b0, first_addr}, 64'd632);

        run_cmd(10'd700, 1'b0, 8'h01, 4'h2, P_SEQ);
        chk("clip700_count", nwr, 0);

        // start_row abort at T+8
        nwr = 0;
        issue(10'd100, 1'b0, 8'h10, 4'h0, P_SEQ);
        for (int k = 1; k <= 8; k++) begin
            step();
            draw_req = 1'b0;
        end
        start_row = 1'b1;
        clear_exp(cyc + 1);
        step();
        start_row = 1'b0;
        #1;
        chk("abort_done", {63'b0, draw_done}, 64'd1);
        repeat (3) step();
        chk("abort_writes", nwr, 6);

        // draw_req coincident with start_row is dropped
        nwr = 0;
        pat = P_SEQ; col_base = 10'd50; flip = 1'b0; frame_id = 8'h22; row_off = 4'h1;
        draw_req = 1'b1; start_row = 1'b1;
        #1;
        chk("drop_rom_en", {63'b0, rom_en}, 64'd0);
        step();
        draw_req = 1'b0; start_row = 1'b0;
        #1;
        chk("drop_done", {63'b0, draw_done}, 64'd1);
        repeat (20) step();
        chk("drop_writes", nwr, 0);

        // asynchronous reset mid-DRAW
        nwr = 0;
        issue(10'd100, 1'b0, 8'h05, 4'h6, P_SEQ);
        for (int k = 1; k <= 5; k++) begin
            step();
            draw_req = 1'b0;
        end
        #2 reset = 1'b0;
        clear_exp(cyc + 1);
        #1;
        chk("arst_we", {63'b0, lb_we}, 64'd0);
        chk("arst_done", {63'b0, draw_done}, 64'd1);
        chk("arst_rom_en", {63'b0, rom_en}, 64'd0);
        step();
        #2 reset = 1'b1;
        repeat (20) step();
        chk("arst_writes", nwr, 3);

        // 4-entry queue driven back to back
        nwr = 0; qi = 0; nrom = 0;
        for (int k = 0; k < 120; k++) begin
            step();
            draw_req = 1'b0;
            #1;
            if (draw_done && qi < 4) begin
                pat = P_SEQ; col_base = qcol[qi]; flip = qi[0];
                frame_id = 8'(qi + 1); row_off = 4'(qi);
                draw_req = 1'b1;
                #1;
                acc[qi] = cyc;
                model(cyc, qcol[qi], qi[0], P_SEQ);
                qi++;
            end else begin
                #1;
            end
            if (rom_en) nrom++;
            if (draw_req) chk("done_vs_req", {63'b0, draw_done}, 64'd0);
            if (qi == 4 && cyc >= acc[3] + 19) break;
        end
        chk("queue_accepts", qi, 4);
        chk("queue_rom_reads", nrom, 4);
        if (qi == 4) begin
            chk("queue_gap1", acc[1] - acc[0], 18);
            chk("queue_gap2", acc[2] - acc[1], 18);
            chk("queue_gap3", acc[3] - acc[2], 18);
        end
        chk("queue_writes", nwr, 64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sprite_drawer.md
# sprite_drawer

Per-sprite row renderer directly downstream of the sprite front end. Accepts one draw command per handshake (column, flip, frame, row offset) and fetches the 16-pixel pattern row from the sprite pattern ROM. Writes the non-transparent pixels into the line buffer being built for the next scanline, clipping at the right screen edge. Reports idle/busy back to the front end through `draw_done`.

## Interface
- `SCREEN_W`, 640, visible width; writes to columns ≥ SCREEN_W are suppressed
- `PIX_W`, 4, bits per pixel (palette index; 0 = transparent)
- `clk`  in  1  sole clock
- `reset`  in  1  asynchronous, active-low reset
- `start_row`  in  1  new-line pulse; aborts any draw in progress
- `draw_req`  in  1  one-cycle command strobe from front end
- `col_base`  in  10  screen column of sprite pixel 0
- `flip`  in  1  horizontal mirror
- `frame_id`  in  8  pattern frame
- `row_off`  in  4  row within the 16×16 sprite
- `draw_done`  out  1  1 = idle, can accept; 0 = busy
- `rom_en`  out  1  pattern ROM read strobe
- `rom_addr`  out  12  `{frame_id,row_off}`
- `rom_data`  in  16·PIX_W  row data, pixel p at `[PIX_W*p +: PIX_W]`; valid the cycle after `rom_en`
- `lb_we`  out  1  line-buffer write enable
- `lb_addr`  out  10  line-buffer column
- `lb_data`  out  PIX_W  pixel value

## Operation
- FSM states: IDLE, LOAD, DRAW.
- IDLE: if `draw_req` is high, drive `rom_en=1` and `rom_addr={frame_id,row_off}` combinationally. Latch `col_base` and `flip`, then go to LOAD. Otherwise `rom_en=0`.
- LOAD: capture `rom_data` into the row register, clear the pixel counter `px`, go to DRAW.
- DRAW: one pixel per cycle, `px` = 0..15. At `px==15`, go to IDLE.
- Pixel select: `flip=0` uses pixel `px`; `flip=1` uses pixel `15-px`.
- Column: 11-bit sum `col = col_base + px`. The write is issued iff pixel ≠ 0 and `col < SCREEN_W`.
- Line-buffer outputs are registered:
  - `lb_we`, `lb_addr=col[9:0]` and `lb_data` take effect on the cycle after the DRAW cycle that computed them.
  - `lb_we=0` in every other cycle.
- `draw_done = (state==IDLE) & ~draw_req`, combinational. This prevents the front end from dequeuing a second command in the cycle its request is presented.
- Overlap: later commands overwrite earlier ones at the same column. There is no read-modify-write.
- `draw_req` while not in IDLE: ignored. The front end must not issue it.
- `start_row` is synchronous abort and has priority over everything:
  - next state is IDLE and `px` is cleared;
  - the registered `lb_we` is 0 in the following cycle;
  - a `draw_req` in the same cycle is dropped and `rom_en` is forced to 0.
- Reset (`reset=0`, asynchronous):
  - state IDLE, `px=0`, row register 0;
  - `lb_we=0`, `lb_addr=0`, `lb_data=0`;
  - `rom_en=0`, and `draw_done=1` given `draw_req=0`.

## Timing
- Command sampled at cycle T (IDLE, `draw_req=1`).
- ROM read issued in T; LOAD in T+1; DRAW in T+2..T+17.
- Line-buffer writes appear in T+3..T+18.
- `draw_done` is 0 in T..T+17 and returns to 1 in T+18 (IDLE).
- A new command may be accepted in T+18. Its ROM read overlaps the final registered write.
- Throughput: 18 cycles per sprite row.
- Worst case on a visible line: 32 sprites × 18 = 576 cycles.
- Clipping: with `col_base=630` only px 0..9 can write. With `col_base ≥ 640` nothing is written, but the full 18-cycle sequence still runs.
- Async reset deasserts cleanly mid-DRAW; no partial write follows.

## Structure
- Shared `sprite_pkg`:
  - `SPR_SIZE=16`, `SCREEN_W=640`, `SCREEN_H=480`, `PIX_W`;
  - `typedef struct packed {col[9:0], flip, frame[7:0], rowoff[3:0]} draw_cmd_t`, also used by the front end's queue;
  - state enum `drw_state_t`.
- No sub-module. The pixel mux, clip compare and counter are inline.

## Test plan
- Reset held low with `draw_req=0` → `draw_done=1`, `lb_we=0`, `rom_en=0`. Release → no writes.
- Req at T with `col=100`, `flip=0`, `frame=3`, `row=5`, all pixels = pixel index + 1 → `rom_addr=0x035` in T. Writes at T+3..T+18 to columns 100..115 with data 1..15 then 0x0? No: data 1..16 is not representable, so use values `p%15+1`. `draw_done` rises at T+18.
- Same command with `flip=1` and pixels 0,2,4,6,8,10,12,14 set to 0 → writes only to odd-distance columns, in mirrored order. Column 100 gets pixel 15.
- `col_base=632` → exactly 8 writes, to columns 632..639. `col_base=700` → zero writes, `draw_done` still low for 18 cycles.
- `start_row` pulsed at T+8 → no `lb_we` from T+9 onward, `draw_done=1` at T+9. `draw_req` with `start_row` at the same cycle → `rom_en=0` and no writes.
- Back-to-back: a 4-entry front end queue driving the block → 4 non-overlapping 18-cycle bursts, `draw_done` never high in a cycle where `draw_req=1`, and every command is consumed exactly once.
